pe_x9_kernel_sequencer: RTL and testbench

- Controller for the 3x3 processing-element array (9 multipliers; weights loaded one kernel row at a time through a one-hot 3-bit row-load select).
- On start: fetches three kernel rows from weight memory and drives the row-load select 100, 010, 001 in order.
- Then streams a programmed number of activation windows into the array under a valid/ready handshake and tracks multiplier latency, so downstream logic gets an aligned product-valid strobe.

---
 rtl/pe_x9_kernel_sequencer_if.sv | 36 +++
 rtl/pe_x9_kernel_sequencer.sv | 137 +++++++++++++
 tb/tb_pe_x9_kernel_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_x9_kernel_sequencer_if.sv
// Bus bundle between the kernel sequencer, the weight memory, the activation
// source and the 3x3 PE array. The sequencer side uses the master modport.
interface pe_x9_kernel_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 12
);
    // job control
    logic                    start;
    logic [ADDR_WIDTH-1:0]   ker_base_addr;
    logic [CNT_WIDTH-1:0]    num_windows;
    logic                    busy;
    logic                    done;
    // weight memory read port
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;
    logic [DATA_WIDTH*3-1:0] w_rd_data;
    logic                    w_rd_valid;
    // PE array weight loading
    logic [2:0]              ker_load;
    logic [DATA_WIDTH*3-1:0] weight_to_pe;
    // activation stream and product strobe
    logic                    act_valid;
    logic                    act_ready;
    logic                    mult_valid;

    modport master (
        input  start, ker_base_addr, num_windows, w_rd_data, w_rd_valid, act_valid,
        output w_rd_en, w_rd_addr, ker_load, weight_to_pe, act_ready, mult_valid, busy, done
    );

    modport slave (
        output start, ker_base_addr, num_windows, w_rd_data, w_rd_valid, act_valid,
        input  w_rd_en, w_rd_addr, ker_load, weight_to_pe, act_ready, mult_valid, busy, done
    );
endinterface

// File: rtl/pe_x9_kernel_sequencer.sv
// Kernel sequencer for the 3x3 PE array: loads three kernel rows from weight
// memory with a one-hot row select, then streams a programmed number of
// activation windows and emits a product-valid strobe aligned to PE latency.
module pe_x9_kernel_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 12,
    parameter int PE_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    pe_x9_kernel_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state, w_state_next;
    logic [1:0]            r_row, w_row_next;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_next;
    logic [CNT_WIDTH-1:0]  r_num, w_num_next;
    logic [ADDR_WIDTH-1:0] r_base, w_base_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
    logic [PE_LATENCY-1:0] r_sr, w_sr_next;

    logic                  w_accept;
    logic                  w_load_hit;
    logic [1:0]            w_row_inc;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [2:0]            w_ker_load;

    assign w_accept   = bus.act_valid && (r_state == S_COMPUTE);
    assign w_load_hit = (r_state == S_LOAD_WAIT) && bus.w_rd_valid;
    assign w_row_inc  = r_row + 2'd1;
    assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);

    // Latency line: stage 0 takes the accept strobe, each later stage the one before.
    assign w_sr_next[0] = w_accept;
    for (genvar gi = 1; gi < PE_LATENCY; gi++) begin : g_lat
        assign w_sr_next[gi] = r_sr[gi-1];
    end

    // State and datapath registers; reset aborts any job and flushes in-flight strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_cnt     <= '0;
            r_num     <= '0;
            r_base    <= '0;
            r_rd_addr <= '0;
            r_sr      <= '0;
        end else begin
            r_state   <= w_state_next;
            r_row     <= w_row_next;
            r_cnt     <= w_cnt_next;
            r_num     <= w_num_next;
            r_base    <= w_base_next;
            r_rd_addr <= w_rd_addr_next;
            r_sr      <= w_sr_next;
        end
    end

    // Next-state logic: row fetch loop, window counting, drain of the latency line.
    always_comb begin
        w_state_next   = r_state;
        w_row_next     = r_row;
        w_cnt_next     = r_cnt;
        w_num_next     = r_num;
        w_base_next    = r_base;
        w_rd_addr_next = r_rd_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_base_next    = bus.ker_base_addr;
                    w_num_next     = bus.num_windows;
                    w_rd_addr_next = bus.ker_base_addr;
                    w_row_next     = 2'd0;
                    w_cnt_next     = '0;
                    w_state_next   = S_LOAD_REQ;
                end
            end
            S_LOAD_REQ: w_state_next = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (bus.w_rd_valid) begin
                    if (r_row != 2'd2) begin
                        w_row_next     = w_row_inc;
                        // address wraps naturally at ADDR_WIDTH bits
                        w_rd_addr_next = r_base + ADDR_WIDTH'(w_row_inc);
                        w_state_next   = S_LOAD_REQ;
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = (r_num == '0) ? S_DONE : S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                if (w_accept) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == r_num) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_sr == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-hot row select, only in the cycle the row data is returned.
    always_comb begin
        w_ker_load = 3'b000;
        if (w_load_hit) begin
            case (r_row)
                2'd0:    w_ker_load = 3'b100;
                2'd1:    w_ker_load = 3'b010;
                default: w_ker_load = 3'b001;
            endcase
        end
    end

    assign bus.w_rd_en      = (r_state == S_LOAD_REQ);
    assign bus.w_rd_addr    = r_rd_addr;
    assign bus.ker_load     = w_ker_load;
    assign bus.weight_to_pe = w_load_hit ? bus.w_rd_data : '0;
    assign bus.act_ready    = (r_state == S_COMPUTE);
    assign bus.mult_valid   = r_sr[PE_LATENCY-1];
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);

endmodule

// File: tb/tb_pe_x9_kernel_sequencer.sv
// Scoreboard bench: two sequencers (PE latency 1 and 3) share one stimulus
// stream and one weight memory model; each has its own monitor.
module tb_pe_x9_kernel_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_in;
    logic [11:0] num_in;
    logic [47:0] mem_data;
    logic        mem_valid;
    logic        act_valid;
    bit          act_mode;
    bit          act_en;
    int          mem_lat;

    int n_vec;
    int n_err;

    logic [9:0]  exp_addr [2][$];
    logic [50:0] exp_load [2][$];
    int          exp_job  [2][$];

    logic        rd_en_v     [2];
    logic [9:0]  rd_addr_v   [2];
    logic [2:0]  ker_load_v  [2];
    logic [47:0] weight_v    [2];
    logic        act_ready_v [2];
    logic        mult_v      [2];
    logic        busy_v      [2];
    logic        done_v      [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int gi, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d got=%h expected=%h at %0t", name, gi, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] rom(input logic [9:0] a);
        if (a == 10'h021) return 48'h0001_0002_0003;
        return {6'h28, a, 6'h2C, a, 6'h30, a};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;

        pe_x9_kernel_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(12)) bus ();

        assign bus.start         = start;
        assign bus.ker_base_addr = base_in;
        assign bus.num_windows   = num_in;
        assign bus.w_rd_data     = mem_data;
        assign bus.w_rd_valid    = mem_valid;
        assign bus.act_valid     = act_valid;

        assign rd_en_v[gi]     = bus.w_rd_en;
        assign rd_addr_v[gi]   = bus.w_rd_addr;
        assign ker_load_v[gi]  = bus.ker_load;
        assign weight_v[gi]    = bus.weight_to_pe;
        assign act_ready_v[gi] = bus.act_ready;
        assign mult_v[gi]      = bus.mult_valid;
        assign busy_v[gi]      = bus.busy;
        assign done_v[gi]      = bus.done;

        pe_x9_kernel_sequencer #(
            .DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(12), .PE_LATENCY(LAT)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        logic [7:0]  hist;
        logic [50:0] e_load;
        logic        exp_m;
        int cyc, acc_cnt, mult_cnt, last_load, last_mult, done_cnt, jn;
        bit prev_done;

        initial done_cnt = 0;

        // Monitor: pops expectations whenever the DUT presents a read, a row load, a product or done.
        always @(negedge clk) begin
            if (rst) begin
                hist = '0; acc_cnt = 0; mult_cnt = 0; prev_done = 0;
                cyc = 0; last_load = 0; last_mult = 0;
            end else begin
                cyc++;
                if (prev_done) begin
                    check("busy_after_done", gi, busy_v[gi], 0);
                    prev_done = 0;
                end
                if (rd_en_v[gi]) begin
                    check("rd_expected", gi, exp_addr[gi].size() != 0, 1);
                    if (exp_addr[gi].size() != 0)
                        check("rd_addr", gi, rd_addr_v[gi], exp_addr[gi].pop_front());
                end
                if (ker_load_v[gi] == 3'b000 && weight_v[gi] != '0)
                    check("weight_idle", gi, weight_v[gi], 0);
                if (ker_load_v[gi] != 3'b000) begin
                    check("load_strobe", gi, mem_valid, 1);
                    check("load_expected", gi, exp_load[gi].size() != 0, 1);
                    if (exp_load[gi].size() != 0) begin
                        e_load = exp_load[gi].pop_front();
                        check("row_load", gi, {ker_load_v[gi], weight_v[gi]}, e_load);
                    end
                    last_load = cyc;
                end
                exp_m = hist[LAT-1];
                if (exp_m || mult_v[gi]) check("mult_valid", gi, mult_v[gi], exp_m);
                if (mult_v[gi]) begin
                    mult_cnt++;
                    last_mult = cyc;
                end
                if (act_valid && act_ready_v[gi]) acc_cnt++;
                hist = {hist[6:0], act_valid && act_ready_v[gi]};
                if (done_v[gi]) begin
                    check("busy_at_done", gi, busy_v[gi], 1);
                    check("done_expected", gi, exp_job[gi].size() != 0, 1);
                    if (exp_job[gi].size() != 0) begin
                        jn = exp_job[gi].pop_front();
                        check("windows_accepted", gi, acc_cnt, jn);
                        check("mult_pulses", gi, mult_cnt, jn);
                        check("done_timing", gi, cyc - ((jn == 0) ? last_load : last_mult),
                              (jn == 0) ? 1 : 2);
                        check("rows_pending", gi, exp_addr[gi].size() + exp_load[gi].size(), 0);
                    end
                    acc_cnt = 0; mult_cnt = 0;
                    done_cnt++;
                    prev_done = 1;
                end
            end
        end
    end

    // Weight memory: responds to each request mem_lat cycles later.
    initial begin
        bit         req;
        logic [9:0] req_addr;
        logic [9:0] pend_addr;
        int         cnt;
        mem_valid = 1'b0;
        mem_data  = '0;
        cnt = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            req      = rd_en_v[0];
            req_addr = rd_addr_v[0];
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_data  = '0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_data  = rom(pend_addr);
                    end
                end
                if (req) begin
                    if (mem_lat == 1) begin
                        mem_valid = 1'b1;
                        mem_data  = rom(req_addr);
                    end else begin
                        cnt       = mem_lat - 1;
                        pend_addr = req_addr;
                    end
                end
            end
        end
    end

    // Activation source: held level or alternating every cycle.
    initial begin
        act_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (act_mode) act_valid = ~act_valid;
            else          act_valid = act_en;
        end
    end

    task automatic push_job(input logic [9:0] base, input int n);
        logic [9:0] a;
        logic [2:0] oh;
        for (int r = 0; r < 3; r++) begin
            a  = base + 10'(r);
            oh = 3'b100 >> r;
            for (int g = 0; g < 2; g++) begin
                exp_addr[g].push_back(a);
                exp_load[g].push_back({oh, rom(a)});
            end
        end
        for (int g = 0; g < 2; g++) exp_job[g].push_back(n);
    endtask

    task automatic pulse_start(input logic [9:0] base, input int n);
        @(posedge clk);
        #1;
        start   = 1'b1;
        base_in = base;
        num_in  = 12'(n);
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic run_job(input logic [9:0] base, input int n, input int lat,
                           input bit toggle, input bit inj);
        int d0, d1, guard, phase;
        mem_lat  = lat;
        act_mode = toggle;
        act_en   = 1'b1;
        d0 = g_dut[0].done_cnt;
        d1 = g_dut[1].done_cnt;
        push_job(base, n);
        pulse_start(base, n);
        guard = 0;
        phase = inj ? 1 : 0;
        while (!(g_dut[0].done_cnt != d0 && g_dut[1].done_cnt != d1 && !busy_v[0] && !busy_v[1])
               && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
            start = 1'b0;
            if (phase == 1 && rd_en_v[0]) phase = 2;
            else if (phase == 2) begin start = 1'b1; phase = 3; end
            else if (phase == 3 && done_v[0]) begin start = 1'b1; phase = 4; end
        end
        start = 1'b0;
        check("job_complete", 0, g_dut[0].done_cnt - d0, 1);
        check("job_complete", 1, g_dut[1].done_cnt - d1, 1);
        if (inj) check("inject_phase", 0, phase, 4);
        repeat (4) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check("no_second_job", g, busy_v[g], 0);
        $display("job base=%h windows=%0d mem_lat=%0d toggle=%0d inject=%0d ended at %0t",
                 base, n, lat, toggle, inj, $time);
    endtask

    initial begin
        int k, guard;
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; base_in = '0; num_in = '0;
        act_mode = 1'b0; act_en = 1'b0; mem_lat = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("reset_ctrl", g, {rd_en_v[g], rd_addr_v[g], ker_load_v[g], act_ready_v[g],
                                    mult_v[g], busy_v[g], done_v[g]}, 0);
            check("reset_weight", g, weight_v[g], 0);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;

        run_job(10'h010, 4, 1, 1'b0, 1'b0);   // basic job
        run_job(10'h020, 3, 3, 1'b0, 1'b0);   // slow memory, row 1 = 1,2,3
        run_job(10'h030, 0, 1, 1'b0, 1'b0);   // zero windows
        run_job(10'h040, 5, 1, 1'b1, 1'b0);   // alternating act_valid

        // abort in COMPUTE after two of six windows
        mem_lat = 1; act_mode = 1'b0; act_en = 1'b1;
        push_job(10'h050, 6);
        pulse_start(10'h050, 6);
        k = 0; guard = 0;
        while (k < 2 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
            if (act_valid && act_ready_v[0]) k++;
        end
        check("abort_windows", 0, k, 2);
        for (int g = 0; g < 2; g++) check("in_compute", g, act_ready_v[g], 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("async_reset_ctrl", g, {rd_en_v[g], rd_addr_v[g], ker_load_v[g], act_ready_v[g],
                                          mult_v[g], busy_v[g], done_v[g]}, 0);
            check("async_reset_weight", g, weight_v[g], 0);
            exp_addr[g].delete();
            exp_load[g].delete();
            exp_job[g].delete();
        end
        $display("job base=050 windows=6 aborted by reset at %0t", $time);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        run_job(10'h060, 2, 1, 1'b0, 1'b0);   // full reload after abort
        run_job(10'h3FF, 1, 3, 1'b0, 1'b1);   // address wrap, ignored starts

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

endmodule
